ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 15 +
 rtl/ram_stream_reader_if.sv | 14 +
 rtl/stream_skid_fifo.sv | 66 ++++++
 rtl/ram_stream_reader.sv | 117 +++++++++++
 tb/tb_ram_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM-to-stream reader: controller state encoding
// and the output FIFO depth.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Words the output FIFO can hold; it also bounds FIFO entries plus reads
  // in flight, which is what keeps backpressure lossless.
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Stream channel (data, valid, ready, last) between the reader and its sink.
interface ram_stream_reader_if #(
  parameter int width = 8
) ();

  logic [width-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry first-word-fall-through FIFO. When empty, a word being pushed is
// visible at the head in the same cycle; if it is popped in that cycle it
// bypasses storage entirely. This lets one RAM word per cycle reach the
// stream with only two storage slots.
module stream_skid_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [width-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             stored;
  logic             bypass;
  logic             do_write;
  logic             do_read;

  // Pointer/occupancy bookkeeping and head/flag decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    stored    = (count_q != 2'd0);
    bypass    = push && !stored && pop;
    do_write  = push && !bypass;
    do_read   = pop && stored;
    wr_ptr_d  = wr_ptr_q ^ do_write;
    rd_ptr_d  = rd_ptr_q ^ do_read;
    count_d   = count_q + {1'b0, do_write} - {1'b0, do_read};
    head_data = stored ? mem_q[rd_ptr_q] : (push ? push_data : '0);
    empty     = !stored && !push;
    full      = (count_q == 2'(FIFO_DEPTH));
    count     = count_q;
  end

  // Control flops; async reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q gates the head, so stale contents are never observed.
    if (do_write) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads num_words consecutive RAM words from base_addr (wrapping) and sends
// them as a stream block, with tlast on the final beat and a done pulse after.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int width      = 8,
  parameter int depth_bits = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [depth_bits-1:0] base_addr,
  input  logic [depth_bits:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  output logic [depth_bits-1:0] read_addr,
  input  logic [width-1:0]      read_data,
  ram_stream_reader_if.master   m
);

  localparam logic [depth_bits:0] NUM_MAX = {1'b1, {depth_bits{1'b0}}};

  state_e                state_q, state_d;
  logic [depth_bits-1:0] addr_q, addr_d;
  logic [depth_bits:0]   left_q, left_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  start_ok;
  logic                  last_hs;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [width:0]        fifo_head;

  assign start_ok  = start && (num_words != '0) && (num_words <= NUM_MAX);
  assign last_hs   = m.m_tvalid && m.m_tready && m.m_tlast;
  assign fifo_pop  = m.m_tready && !fifo_empty;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign read_addr = addr_q;

  // Each word carries its tlast flag through the FIFO.
  stream_skid_fifo #(.width(width + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, read_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m.m_tvalid = !fifo_empty;
  assign m.m_tlast  = fifo_head[width];
  assign m.m_tdata  = fifo_head[width-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept a valid start, finish on the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_STREAM;
      ST_STREAM: if (last_hs)  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; read_en depends only on flops, never on m_tready.
  always_comb begin
    busy    = (state_q == ST_STREAM);
    done    = (state_q == ST_FINISH);
    read_en = (state_q == ST_STREAM) && (left_q != '0) && !fifo_full &&
              (occupancy < 3'(FIFO_DEPTH));
  end

  // Address / remaining-read counters and the in-flight tracker.
  always_comb begin
    addr_d          = addr_q;
    left_d          = left_q;
    inflight_d      = read_en;
    inflight_last_d = read_en && (left_q == (depth_bits + 1)'(1));
    if (state_q == ST_IDLE && start_ok) begin
      addr_d = base_addr;
      left_d = num_words;
    end else if (read_en) begin
      addr_d = addr_q + depth_bits'(1);
      left_d = left_q - (depth_bits + 1)'(1);
    end
  end

  // Datapath registers; reset abandons any block in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      left_q          <= left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a queue scoreboard: tests push
// the expected beats, a monitor pops and compares on every handshake.
module tb_ram_stream_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] num_words;
  logic       busy;
  logic       done;
  logic       read_en;
  logic [1:0] read_addr;
  logic [7:0] read_data;
  logic       tready;

  int checks;
  int failures;
  int beats;

  logic [8:0] exp_q[$];
  logic [1:0] addr_log[$];
  logic [7:0] ram [4];
  bit         pat [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1};

  ram_stream_reader_if #(.width(8)) s_if ();
  assign s_if.m_tready = tready;

  ram_stream_reader #(.width(8), .depth_bits(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .read_en   (read_en),
    .read_addr (read_addr),
    .read_data (read_data),
    .m         (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM: data one cycle after read_en; log every address read.
  initial begin
    read_data = 8'h00;
    forever begin
      @(posedge clk);
      if (read_en === 1'b1) begin
        read_data <= ram[read_addr];
        addr_log.push_back(read_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: score each handshake and check that a stalled beat stays put.
  initial begin
    logic       held_v;
    logic [8:0] held;
    logic [8:0] e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_valid_held", 32'(s_if.m_tvalid), 32'd1);
          check("stall_beat_stable", 32'({s_if.m_tlast, s_if.m_tdata}), 32'(held));
        end
        if (s_if.m_tvalid && tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", {s_if.m_tlast, s_if.m_tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat_last_data", 32'({s_if.m_tlast, s_if.m_tdata}), 32'(e));
          end
          held_v = 1'b0;
        end else if (s_if.m_tvalid) begin
          held_v = 1'b1;
          held   = {s_if.m_tlast, s_if.m_tdata};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] b, input logic [2:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    check(name, 32'(done), 32'd1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_en"},   32'(read_en),       32'd0);
    check({tag, "_tvalid"},    32'(s_if.m_tvalid), 32'd0);
    check({tag, "_tlast"},     32'(s_if.m_tlast),  32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_read_addr"}, 32'(read_addr),     32'd0);
    check({tag, "_tdata"},     32'(s_if.m_tdata),  32'd0);
  endtask

  task automatic push_block4();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h44});
  endtask

  task automatic check_addrs(input string name, input logic [1:0] a0, input logic [1:0] a1,
                             input logic [1:0] a2, input logic [1:0] a3, input int n);
    logic [1:0] want [4];
    logic [31:0] got;
    want = '{a0, a1, a2, a3};
    check({name, "_count"}, 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hffff_ffff;
      check({name, "_addr"}, got, 32'(want[i]));
    end
  endtask

  initial begin
    int acc;
    int b0;
    int k;
    checks    = 0;
    failures  = 0;
    beats     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    tready    = 1'b1;
    ram       = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full block, sink always ready: back-to-back beats, tlast, done timing.
    push_block4();
    addr_log.delete();
    pulse_start(2'd0, 3'd4);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_first_read_en", 32'(read_en), 32'd1);
    check("t1_first_read_addr", 32'(read_addr), 32'd0);
    check("t1_valid_not_yet", 32'(s_if.m_tvalid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid_back_to_back", 32'(s_if.m_tvalid), 32'd1);
      check("t1_tlast", 32'(s_if.m_tlast), 32'(i == 3));
      check("t1_done_early", 32'(done), 32'd0);
      if (i < 3) step();
    end
    step();
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_busy_low_with_done", 32'(busy), 32'd0);
    step();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check_addrs("t1", 2'd0, 2'd1, 2'd2, 2'd3, 4);

    // Wrapping block: base 3, three words.
    exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    addr_log.delete();
    pulse_start(2'd3, 3'd3);
    wait_done("t2_done", 20);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check_addrs("t2", 2'd3, 2'd0, 2'd1, 2'd0, 3);

    // Toggling ready: same order, no drop or duplicate, stable while stalled.
    push_block4();
    addr_log.delete();
    fork
      begin
        pulse_start(2'd0, 3'd4);
        wait_done("t3_done", 60);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          tready = (i < 12) ? pat[i] : 1'b1;
          step();
        end
      end
    join
    tready = 1'b1;
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check_addrs("t3", 2'd0, 2'd1, 2'd2, 2'd3, 4);

    // Long stall: reads capped by FIFO capacity, beats resume intact.
    tready = 1'b0;
    push_block4();
    addr_log.delete();
    pulse_start(2'd0, 3'd4);
    repeat (20) step();
    check("t4_reads_while_stalled_le2", 32'(addr_log.size() <= 2), 32'd1);
    check("t4_read_en_low_when_full", 32'(read_en), 32'd0);
    check("t4_valid_held", 32'(s_if.m_tvalid), 32'd1);
    check("t4_head_data", 32'(s_if.m_tdata), 32'h11);
    tready = 1'b1;
    wait_done("t4_done", 20);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check_addrs("t4", 2'd0, 2'd1, 2'd2, 2'd3, 4);

    // Reset after beat 2, then a fresh block from base 1.
    push_block4();
    b0 = beats;
    pulse_start(2'd0, 3'd4);
    k = 0;
    while (beats < b0 + 2 && k < 20) begin
      step();
      k++;
    end
    check("t5_two_beats_before_reset", 32'(beats - b0), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    step();
    step();
    check("t5_idle_valid", 32'(s_if.m_tvalid), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    pulse_start(2'd1, 3'd2);
    wait_done("t5_done", 20);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Out-of-range lengths are ignored.
    pulse_start(2'd0, 3'd0);
    acc = 0;
    repeat (4) begin
      acc = acc | int'(busy) | int'(read_en);
      step();
    end
    check("t6_num0_ignored", 32'(acc), 32'd0);
    pulse_start(2'd0, 3'd5);
    acc = 0;
    repeat (4) begin
      acc = acc | int'(busy) | int'(read_en);
      step();
    end
    check("t6_num5_ignored", 32'(acc), 32'd0);

    // Start while busy has no effect on the running block.
    push_block4();
    addr_log.delete();
    pulse_start(2'd0, 3'd4);
    step();
    pulse_start(2'd2, 3'd1);
    wait_done("t6_done", 20);
    acc = 0;
    repeat (4) begin
      acc = acc | int'(busy) | int'(read_en);
      step();
    end
    check("t6_no_second_block", 32'(acc), 32'd0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check_addrs("t6", 2'd0, 2'd1, 2'd2, 2'd3, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
